// File: rtl/pipe_pkg.sv
// pipe_pkg: instruction flag bit positions and stall FSM state encoding
package pipe_pkg;
  localparam int F_MEM_RD  = 0;
  localparam int F_REG_WR  = 1;
  localparam int F_BRANCH  = 2;
  localparam int F_JUMP    = 3;
  localparam int F_MULDIV  = 4;
  localparam int F_USE_RS1 = 5;
  localparam int F_USE_RS2 = 6;
  typedef enum logic [1:0] {RUN = 2'd0, LD_STALL = 2'd1, MD_WAIT = 2'd2} state_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use compare between the S3 consumer and the load sitting at the S3/S4 latch output
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [15:0] id_flags,
  input  logic [4:0]  ex_rd,
  input  logic [15:0] ex_flags,
  output logic        load_use
);
  logic unused_flags;
  assign unused_flags = ^{id_flags[15:7], id_flags[4:0], ex_flags[15:1]};
  assign load_use = ex_flags[F_MEM_RD] && ex_rd != 5'd0 &&
                    ((id_flags[F_USE_RS1] && id_rs1 == ex_rd) || (id_flags[F_USE_RS2] && id_rs2 == ex_rd));
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline latch enable/flush control for load-use, mul/div occupancy and taken branches
module hazard_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int LD_STALL_CYCLES = 1,
  parameter int MD_TIMEOUT      = 64,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [15:0]      id_flags,
  input  logic [4:0]       ex_rd,
  input  logic [15:0]      ex_flags,
  input  logic             br_taken,
  input  logic             md_done,
  output logic             pc_en,
  output logic             en_s1_s2,
  output logic             en_s2_s3,
  output logic             en_s3_s4,
  output logic             flush_s2_s3,
  output logic             flush_s3_s4,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_count
);
  state_t           state_q, state_d;
  logic [2:0]       ld_cnt_q, ld_cnt_d;
  logic [7:0]       md_cnt_q, md_cnt_d, md_inc;
  logic             md_err_q, md_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;
  hazard_detect u_hazard_detect (
    .id_rs1   (id_rs1),
    .id_rs2   (id_rs2),
    .id_flags (id_flags),
    .ex_rd    (ex_rd),
    .ex_flags (ex_flags),
    .load_use (load_use)
  );
  assign md_inc      = &md_cnt_q ? md_cnt_q : md_cnt_q + 8'd1;
  assign md_err      = md_err_q;
  assign stall_count = stall_cnt_q;
  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    md_cnt_d    = md_cnt_q;
    md_err_d    = md_err_q;
    pc_en       = 1'b1;
    en_s1_s2    = 1'b1;
    en_s2_s3    = 1'b1;
    en_s3_s4    = 1'b1;
    flush_s2_s3 = 1'b0;
    flush_s3_s4 = 1'b0;
    case (state_q)
      RUN: begin
        if (br_taken) begin
          flush_s2_s3 = 1'b1;
          flush_s3_s4 = 1'b1;
        end else if (ex_flags[F_MULDIV] && !md_done) begin
          pc_en    = 1'b0;
          en_s1_s2 = 1'b0;
          en_s2_s3 = 1'b0;
          en_s3_s4 = 1'b0;
          state_d  = MD_WAIT;
          md_cnt_d = 8'd1;
        end else if (load_use) begin
          pc_en       = 1'b0;
          en_s1_s2    = 1'b0;
          en_s2_s3    = 1'b0;
          flush_s3_s4 = 1'b1;
          state_d     = LD_STALL_CYCLES > 1 ? LD_STALL : RUN;
          ld_cnt_d    = 3'd1;
        end
      end
      LD_STALL: begin
        if (br_taken) begin
          flush_s2_s3 = 1'b1;
          flush_s3_s4 = 1'b1;
          state_d     = RUN;
        end else begin
          pc_en       = 1'b0;
          en_s1_s2    = 1'b0;
          en_s2_s3    = 1'b0;
          flush_s3_s4 = 1'b1;
          ld_cnt_d    = ld_cnt_q + 3'd1;
          state_d     = ld_cnt_q == 3'(LD_STALL_CYCLES - 1) ? RUN : LD_STALL;
        end
      end
      MD_WAIT: begin
        // S4 is frozen here, so a branch cannot resolve and br_taken is ignored
        if (md_done) begin
          state_d = RUN;
        end else if (md_inc == 8'(MD_TIMEOUT)) begin
          md_err_d = 1'b1;
          state_d  = RUN;
        end else begin
          pc_en    = 1'b0;
          en_s1_s2 = 1'b0;
          en_s2_s3 = 1'b0;
          en_s3_s4 = 1'b0;
          md_cnt_d = md_inc;
        end
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      pc_en       = 1'b0;
      en_s1_s2    = 1'b0;
      en_s2_s3    = 1'b0;
      en_s3_s4    = 1'b0;
      flush_s2_s3 = 1'b1;
      flush_s3_s4 = 1'b1;
    end
    stall_cnt_d = (!pc_en && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      ld_cnt_q    <= '0;
      md_cnt_q    <= '0;
      md_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      md_cnt_q    <= md_cnt_d;
      md_err_q    <= md_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule
